if_stage: RTL and testbench

Instruction-fetch stage of the pipeline: owns the program counter, issues single-outstanding requests to instruction memory, and buffers up to two fetched words in a small FIFO. Its outputs feed the decode stage directly. It absorbs decode stalls without dropping words and redirects to a new PC on a flush from branch/exception logic. Every flush, including one that lands mid-transaction, is handled without corrupting the memory handshake.

---
 rtl/if_stage.sv | 136 +++++++++++++
 tb/tb_if_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, 2-entry fetch FIFO.
// Optional misaligned-redirect trap (HALT state, fetch_misalign_o) under IF_MISALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  typedef enum logic [1:0] {
    FETCH,
    DRAIN
`ifdef IF_MISALIGN_CHECK_EN
    ,
    HALT
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] tgt_pc, tgt_pc_n;
  logic [31:0] load_pc;

  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic req, push, pop;

  assign req  = !rst && ((state == FETCH && count != 2'd2) || state == DRAIN);
  assign push = !flush_i && state == FETCH && req && imem_ack_i;
  assign pop  = id_valid_o && !stall_i;

`ifdef IF_MISALIGN_CHECK_EN
  assign load_pc = new_pc_i;
`else
  assign load_pc = new_pc_i & ~32'h3;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    tgt_pc_n   = tgt_pc;
    if (flush_i) begin
      // An unacked request must complete at its old address before redirecting.
      if (req && !imem_ack_i) begin
        tgt_pc_n = load_pc;
        state_n  = DRAIN;
      end else begin
`ifdef IF_MISALIGN_CHECK_EN
        if (load_pc[1:0] != 2'b00) begin
          state_n = HALT;
        end else begin
          fetch_pc_n = load_pc;
          state_n    = FETCH;
        end
`else
        fetch_pc_n = load_pc;
        state_n    = FETCH;
`endif
      end
    end else begin
      case (state)
        FETCH: if (push) fetch_pc_n = fetch_pc + 32'd4;
        DRAIN: if (imem_ack_i) begin
          fetch_pc_n = tgt_pc;
          state_n    = FETCH;
`ifdef IF_MISALIGN_CHECK_EN
          if (tgt_pc[1:0] != 2'b00) state_n = HALT;
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      tgt_pc   <= 32'h0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      tgt_pc   <= tgt_pc_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_inst[wr_ptr] <= imem_data_i;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = rst ? RESET_PC : fetch_pc;
  assign id_valid_o  = !rst && count != 2'd0;
  assign id_pc_o     = id_valid_o ? fifo_pc[rd_ptr]   : 32'h0;
  assign id_inst_o   = id_valid_o ? fifo_inst[rd_ptr] : 32'h0;

`ifdef IF_MISALIGN_CHECK_EN
  assign fetch_misalign_o = !rst && state == HALT;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand sequences for wrap and
// misaligned redirect, then randomized traffic checked against a queue-based model.
module tb_if_stage;

`ifdef IF_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, imem_ack_i;
  logic [31:0] new_pc_i, imem_data_i;
  logic        imem_req_o, id_valid_o;
  logic [31:0] imem_addr_o, id_pc_o, id_inst_o;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misalign_o;
`endif

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .new_pc_i    (new_pc_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .id_valid_o  (id_valid_o),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic ev, input logic [31:0] epc, input logic [31:0] einst);
    check({tag, ".req"},   {31'b0, imem_req_o}, {31'b0, ereq});
    check({tag, ".addr"},  imem_addr_o, eaddr);
    check({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, ev});
    check({tag, ".pc"},    id_pc_o, epc);
    check({tag, ".inst"},  id_inst_o, einst);
  endtask

  // Drive inputs just after the falling edge; outputs are then sampled mid-cycle.
  task automatic apply(input logic s, input logic f, input logic [31:0] np,
                       input logic a, input logic [31:0] d);
    stall_i = s; flush_i = f; new_pc_i = np; imem_ack_i = a; imem_data_i = d;
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic [31:0] np, input logic a,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.flush = f; v.new_pc = np; v.ack = a;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Behavioural reference: fetched words as a queue, plus redirect bookkeeping.
  entry_t      m_q[$];
  logic [31:0] m_pc, m_tgt;
  bit          m_drain, m_halt;
  int          mem_wait;

  vec_t tbl[18];

  logic        r_s, r_f, r_a, r_req, r_pop, r_mis;
  logic [31:0] r_np, r_d, r_load;

  initial begin
    // Zero-wait memory returning the address as data; ack only while req is expected high.
    tbl[0]  = mk(0, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0);
    tbl[2]  = mk(1, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4);
    tbl[3]  = mk(1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h4);
    tbl[4]  = mk(1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h4);
    tbl[5]  = mk(1, 0, 32'h0,   0, 0, 32'hC,   1, 32'h4);
    tbl[6]  = mk(0, 0, 32'h0,   0, 0, 32'hC,   1, 32'h4);
    tbl[7]  = mk(0, 0, 32'h0,   1, 1, 32'hC,   1, 32'h8);
    tbl[8]  = mk(0, 1, 32'h200, 1, 1, 32'h10,  1, 32'hC);
    tbl[9]  = mk(0, 0, 32'h0,   1, 1, 32'h200, 0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h200);
    tbl[11] = mk(0, 1, 32'h100, 0, 1, 32'h204, 0, 32'h0);
    tbl[12] = mk(0, 0, 32'h0,   0, 1, 32'h204, 0, 32'h0);
    tbl[13] = mk(0, 0, 32'h0,   1, 1, 32'h204, 0, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h0);
    tbl[15] = mk(0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h100);
    tbl[16] = mk(0, 1, 32'h40,  1, 1, 32'h104, 0, 32'h0);
    tbl[17] = mk(0, 0, 32'h0,   0, 1, 32'h40,  0, 32'h0);

    rst = 1'b1;
    apply(0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check_out("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].stall, tbl[i].flush, tbl[i].new_pc, tbl[i].ack, tbl[i].exp_addr);
      check_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_valid,
                tbl[i].exp_pc, tbl[i].exp_valid ? tbl[i].exp_pc : 32'h0);
      @(negedge clk);
    end

    // PC wrap: redirect to the last word, fetch it, next address is 0.
    apply(0, 1, 32'hFFFF_FFFC, 1, 32'h40);
    @(negedge clk);
    apply(0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    check("wrap.addr_hi", imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk);
    apply(0, 0, 32'h0, 0, 32'h0);
    check("wrap.addr_lo", imem_addr_o, 32'h0);
    check("wrap.id_pc", id_pc_o, 32'hFFFF_FFFC);
    check("wrap.id_inst", id_inst_o, 32'hFFFF_FFFC);
    @(negedge clk);

    // Misaligned redirect target.
    apply(0, 1, 32'h102, 1, 32'h0);
    @(negedge clk);
    apply(0, 0, 32'h0, 0, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
    check("mis.req", {31'b0, imem_req_o}, 32'h0);
    check("mis.flag", {31'b0, fetch_misalign_o}, 32'h1);
    @(negedge clk);
    apply(0, 1, 32'h104, 0, 32'h0);
    @(negedge clk);
    apply(0, 0, 32'h0, 0, 32'h0);
    check("mis.clear", {31'b0, fetch_misalign_o}, 32'h0);
    check("mis.req_back", {31'b0, imem_req_o}, 32'h1);
    check("mis.addr_back", imem_addr_o, 32'h104);
`else
    check("mis.req", {31'b0, imem_req_o}, 32'h1);
    check("mis.addr", imem_addr_o, 32'h100);
`endif
    @(negedge clk);

    // Reset in the middle of traffic, then randomized run against the model.
    rst = 1'b1;
    apply(0, 0, 32'h0, 0, 32'h0);
    check_out("rst_mid", 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_pc = 32'h0; m_tgt = 32'h0; m_drain = 0; m_halt = 0; mem_wait = -1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_req = !m_halt && (m_drain || m_q.size() < 2);
      r_s   = ($urandom % 10) < 3;
      r_f   = ($urandom % 12) == 0;
      case ($urandom % 4)
        0:       r_np = $urandom;
        1:       r_np = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: r_np = $urandom & 32'h3FF;
      endcase
      if (r_req) begin
        if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
        r_a = (mem_wait == 0);
        if (r_a) mem_wait = -1;
        else mem_wait--;
      end else begin
        r_a = 1'b0;
        mem_wait = -1;
      end
      r_d = r_a ? (m_pc ^ 32'h5A5A_0FF0) : $urandom;

      apply(r_s, r_f, r_np, r_a, r_d);
      check_out($sformatf("rnd%0d", cyc), r_req, m_pc, m_q.size() > 0,
                m_q.size() > 0 ? m_q[0].pc : 32'h0, m_q.size() > 0 ? m_q[0].inst : 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
      check($sformatf("rnd%0d.misalign", cyc), {31'b0, fetch_misalign_o}, {31'b0, m_halt});
`endif

      r_pop  = m_q.size() > 0 && !r_s;
      r_load = CHK ? r_np : (r_np & ~32'h3);
      r_mis  = CHK && r_np[1:0] != 2'b00;
      if (r_f) begin
        m_q.delete();
        if (r_req && !r_a) begin
          m_drain = 1;
          m_tgt   = r_load;
        end else begin
          m_drain = 0;
          if (r_mis) m_halt = 1;
          else begin
            m_halt = 0;
            m_pc   = r_load;
          end
        end
      end else if (m_drain) begin
        if (r_a) begin
          m_drain = 0;
          m_pc    = m_tgt;
          if (CHK && m_tgt[1:0] != 2'b00) m_halt = 1;
        end
      end else begin
        if (r_pop) void'(m_q.pop_front());
        if (r_a) begin
          m_q.push_back('{pc: m_pc, inst: r_d});
          m_pc = m_pc + 32'd4;
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
